channel_capture_ctrl: RTL and testbench

Capture/readback controller for one logic-analyzer channel buffer. Generates write addresses and write enables into an external ENTRIES-deep synchronous-read RAM queue. It writes a circular pre-trigger/post-trigger sample window, then walks the whole buffer oldest-first on request. It sits between the trigger logic, the sample-rate strobe and the command/UART dump path.

---
 rtl/channel_capture_ctrl.sv | 128 ++++++++++++
 tb/tb_channel_capture_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/channel_capture_ctrl.sv
// Capture/readback sequencer for one logic-analyzer channel buffer.
// Drives a circular pre/post-trigger write window, then dumps the buffer oldest-first.
module channel_capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            start_rd,
    input  logic            triggered,
    input  logic [5:0]      TrigCfg,
    input  logic            wrt_smpl,
    input  logic [LOG2-1:0] trig_pos,
    output logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    output logic            we,
    output logic            armed,
    output logic            capture_done,
    output logic            read_done
);

    // state     | meaning
    // IDLE      | waiting for run or start_rd
    // WRT_SMPL  | writing samples, pre-trigger fill then post-trigger count
    // CAPT_DONE | window complete, wr_ptr is the oldest sample
    // CHANDUMP  | walking the whole buffer oldest-first
    typedef enum logic [1:0] {IDLE, WRT_SMPL, CHANDUMP, CAPT_DONE} state_t;

    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   DEPTH     = (LOG2 + 1)'(ENTRIES);
    localparam logic [LOG2:0]   LAST_CNT  = (LOG2 + 1)'(ENTRIES - 1);

    state_t          state;
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2-1:0] trig_cnt;
    logic [LOG2:0]   smpl_cnt;
    logic [LOG2:0]   rd_cnt;
    logic [LOG2:0]   arm_thresh;
    logic            trig_seen;
    logic            capt_end;
    logic            unused_cfg;

    function automatic logic [LOG2-1:0] wrap_inc(input logic [LOG2-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign unused_cfg = ^TrigCfg[4:0];

    // An oversize trig_pos would underflow the threshold; arm immediately instead.
    assign arm_thresh = ({1'b0, trig_pos} >= DEPTH) ? '0 : DEPTH - {1'b0, trig_pos};

    assign capt_end = (state == WRT_SMPL) && wrt_smpl && trig_seen &&
                      ((trig_pos == '0) || (trig_cnt + 1'b1 == trig_pos));

    assign waddr = wr_ptr;
    assign raddr = (state == CHANDUMP) ? rd_ptr : wr_ptr;
    assign we    = (state == WRT_SMPL) && wrt_smpl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            trig_cnt     <= '0;
            smpl_cnt     <= '0;
            rd_cnt       <= '0;
            trig_seen    <= 1'b0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            read_done    <= 1'b0;
        end else begin
            read_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run && !TrigCfg[5]) begin
                        state     <= WRT_SMPL;
                        smpl_cnt  <= '0;
                        trig_cnt  <= '0;
                        trig_seen <= 1'b0;
                        armed     <= 1'b0;
                    end else if (start_rd) begin
                        state  <= CHANDUMP;
                        rd_ptr <= wrap_inc(wr_ptr);
                        rd_cnt <= (LOG2 + 1)'(1);
                    end
                end
                WRT_SMPL: begin
                    if (wrt_smpl)
                        wr_ptr <= wrap_inc(wr_ptr);
                    if (!armed && smpl_cnt >= arm_thresh)
                        armed <= 1'b1;
                    if (armed && triggered)
                        trig_seen <= 1'b1;
                    if (wrt_smpl && !trig_seen && smpl_cnt != DEPTH)
                        smpl_cnt <= smpl_cnt + 1'b1;
                    if (wrt_smpl && trig_seen)
                        trig_cnt <= trig_cnt + 1'b1;
                    if (capt_end) begin
                        state        <= CAPT_DONE;
                        capture_done <= 1'b1;
                        armed        <= 1'b0;
                    end
                end
                CAPT_DONE: begin
                    if (start_rd) begin
                        state  <= CHANDUMP;
                        rd_ptr <= wrap_inc(wr_ptr);
                        rd_cnt <= (LOG2 + 1)'(1);
                    end
                end
                CHANDUMP: begin
                    rd_ptr <= wrap_inc(rd_ptr);
                    rd_cnt <= rd_cnt + 1'b1;
                    // The first address went out from IDLE/CAPT_DONE, so the last one is at ENTRIES-1.
                    if (rd_cnt == LAST_CNT) begin
                        state        <= IDLE;
                        read_done    <= 1'b1;
                        capture_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_capture_ctrl.sv
// Directed bench for channel_capture_ctrl with a behavioural sync-read RAM.
// Expected addresses and data are hand-derived from the sample numbering.
module tb_channel_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, start_rd, triggered, wrt_smpl;
    logic [5:0] TrigCfg;
    logic [8:0] trig_pos;
    logic [8:0] waddr, raddr;
    logic       we, armed, capture_done, read_done;

    logic [15:0] mem [0:511];
    logic [15:0] rdata, wdata;
    logic        preload;
    int          scnt;
    int          n_chk = 0;
    int          n_err = 0;

    channel_capture_ctrl #(.ENTRIES(384), .LOG2(9)) dut (
        .clk(clk), .rst(rst), .run(run), .start_rd(start_rd), .triggered(triggered),
        .TrigCfg(TrigCfg), .wrt_smpl(wrt_smpl), .trig_pos(trig_pos),
        .waddr(waddr), .raddr(raddr), .we(we), .armed(armed),
        .capture_done(capture_done), .read_done(read_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 16'(i % 256);
        end else if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int gap);
        scnt++;
        wdata    = scnt[15:0];
        wrt_smpl = 1'b1;
        step();
        wrt_smpl = 1'b0;
        repeat (gap - 1) step();
    endtask

    initial begin
        int pulses;
        int we_seen;
        rst = 1'b1; run = 0; start_rd = 0; triggered = 0; wrt_smpl = 0;
        TrigCfg = '0; trig_pos = '0; wdata = '0; scnt = 0; preload = 1'b1;
        step(); step();
        preload = 1'b0;
        rst = 1'b0;
        chk("rst_waddr", waddr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_we", we, 0);
        chk("rst_armed", armed, 0);
        chk("rst_capture_done", capture_done, 0);
        chk("rst_read_done", read_done, 0);

        // Dump of preloaded RAM with no capture
        start_rd = 1'b1;
        chk("d1_raddr0", raddr, 0);
        step();
        start_rd = 1'b0;
        for (int k = 1; k < 384; k++) begin
            chk("d1_raddr", raddr, k);
            chk("d1_rdata", rdata, (k - 1) % 256);
            chk("d1_read_done_low", read_done, 0);
            step();
        end
        chk("d1_rdata_last", rdata, 127);
        chk("d1_read_done", read_done, 1);
        step();
        chk("d1_read_done_pulse", read_done, 0);
        chk("d1_idle_raddr", raddr, 0);

        // Reset in the middle of a dump
        start_rd = 1'b1;
        step();
        start_rd = 1'b0;
        repeat (98) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("d2_raddr_after_rst", raddr, 0);
        chk("d2_read_done_after_rst", read_done, 0);
        pulses = 0;
        for (int i = 0; i < 400; i++) begin
            if (read_done) pulses++;
            step();
        end
        chk("d2_no_read_done", pulses, 0);

        // Capture-done flag still set in config: run must be ignored
        TrigCfg = 6'h20;
        run = 1'b1;
        step();
        run = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 20; i++) begin
            wrt_smpl = 1'b1;
            #1;
            if (we) we_seen++;
            step();
            wrt_smpl = 1'b0;
            step();
        end
        chk("cfg_we_never", we_seen, 0);
        chk("cfg_waddr", waddr, 0);
        TrigCfg = '0;

        // trig_pos=100 capture, strobe every 4 clocks
        trig_pos = 9'd100;
        scnt = 0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int n = 1; n <= 283; n++) begin
            if (n == 50) triggered = 1'b1;
            if (n == 61) triggered = 1'b0;
            strobe(4);
        end
        chk("c4_armed_283", armed, 0);
        scnt++;
        wdata = scnt[15:0];
        wrt_smpl = 1'b1;
        #1;
        chk("c4_we_strobe", we, 1);
        step();
        wrt_smpl = 1'b0;
        chk("c4_armed_at_284", armed, 0);
        step();
        chk("c4_armed_after_284", armed, 1);
        step(); step();
        for (int n = 0; n < 50; n++) strobe(4);
        chk("c4_not_done_pre", capture_done, 0);
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        for (int n = 0; n < 99; n++) strobe(4);
        chk("c4_not_done_99", capture_done, 0);
        chk("c4_armed_99", armed, 1);
        strobe(1);
        chk("c4_capture_done", capture_done, 1);
        chk("c4_armed_cleared", armed, 0);
        chk("c4_final_waddr", waddr, 50);
        wrt_smpl = 1'b1;
        #1;
        chk("c4_we_stopped", we, 0);
        step();
        wrt_smpl = 1'b0;
        chk("c4_waddr_held", waddr, 50);
        chk("c4_done_held", capture_done, 1);

        // Dump the captured window oldest-first
        start_rd = 1'b1;
        chk("d4_raddr0", raddr, 50);
        step();
        start_rd = 1'b0;
        for (int j = 1; j < 384; j++) begin
            chk("d4_raddr", raddr, (50 + j) % 384);
            chk("d4_rdata", rdata, 50 + j);
            step();
        end
        chk("d4_rdata_last", rdata, 434);
        chk("d4_read_done", read_done, 1);
        chk("d4_capture_cleared", capture_done, 0);

        // trig_pos=0 capture
        trig_pos = 9'd0;
        run = 1'b1;
        step();
        run = 1'b0;
        for (int n = 0; n < 383; n++) strobe(2);
        chk("c0_armed_383", armed, 0);
        strobe(1);
        chk("c0_armed_at_384", armed, 0);
        step();
        chk("c0_armed_after_384", armed, 1);
        triggered = 1'b1;
        step();
        triggered = 1'b0;
        chk("c0_not_done", capture_done, 0);
        strobe(1);
        chk("c0_capture_done", capture_done, 1);
        chk("c0_armed_cleared", armed, 0);
        chk("c0_final_waddr", waddr, 51);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
